// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and defaults for the IF/MEM memory port arbiter
package riscv_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_REQ  = 2'd1;
    localparam arb_state_t ST_WAIT = 2'd2;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - one-entry fetch buffer with word tag compare and store-snoop invalidate
module ifetch_buf #(
    parameter int TAG_W  = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              snoop_en,
    input  logic [TAG_W-1:0]  snoop_tag
);

    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;

    // Fills and store snoops never coincide: only one memory transaction is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (snoop_en && valid && (snoop_tag == tag)) begin
            valid <= 1'b0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end
    end

    assign hit      = valid && (tag == lookup_tag);
    assign hit_data = data;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM shared memory port sequencer; IFETCH_BUF_EN adds a one-entry fetch buffer
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state;
    owner_t     owner;
    logic       kill;
    logic       d_start;
    logic       i_want;
    logic       i_start;
    logic       resp;

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req & ~d_done;

    // A requester whose done pulse is out this cycle already has its answer.
    assign d_start = (state == ST_IDLE) & d_req & ~d_done;
    assign i_want  = (state == ST_IDLE) & if_req & ~if_done & ~flush & ~d_start;
    assign resp    = (((state == ST_REQ) & mem_gnt) | (state == ST_WAIT)) & mem_rvalid;

`ifdef IFETCH_BUF_EN
    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;

    ifetch_buf #(
        .TAG_W  (ADDR_W - 2),
        .DATA_W (DATA_W)
    ) u_ifetch_buf (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (if_addr[ADDR_W-1:2]),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .fill_en    (resp & (owner == OWN_I) & ~kill & ~flush),
        .fill_tag   (mem_addr[ADDR_W-1:2]),
        .fill_data  (mem_rdata),
        .snoop_en   ((state == ST_REQ) & mem_gnt & mem_we),
        .snoop_tag  (mem_addr[ADDR_W-1:2])
    );

    assign i_start = i_want & ~buf_hit;
`else
    assign i_start = i_want;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_I;
            kill      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    kill <= 1'b0;
                    if (d_start) begin
                        owner     <= OWN_D;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        mem_req   <= 1'b1;
                        state     <= ST_REQ;
                    end else if (i_start) begin
                        owner     <= OWN_I;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                        mem_req   <= 1'b1;
                        state     <= ST_REQ;
                    end
`ifdef IFETCH_BUF_EN
                    else if (i_want) begin
                        if_done  <= 1'b1;
                        if_rdata <= buf_data;
                    end
`endif
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_rvalid ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A killed fetch still drains on the memory side; only its result is dropped.
            if ((state != ST_IDLE) && (owner == OWN_I))
                kill <= ~resp & (kill | flush);

            if (resp) begin
                if (owner == OWN_D) begin
                    d_done  <= 1'b1;
                    d_rdata <= mem_rdata;
                end else if (!kill && !flush) begin
                    if_done  <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
